// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// path (IF, read only) and the load/store path (LS). One request is accepted
// per arbitration slot (IDLE or RESP), followed by LATENCY access cycles and a
// one-cycle response. Simultaneous requests alternate owners.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store port
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_valid,
  output logic [DATA_W-1:0] ls_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // status
  output logic              busy
);

  // Counter only needs to reach LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_ls_q, last_ls_d;
  logic              owner_ls_q, owner_ls_d;

  logic              if_gnt_q, if_gnt_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic              ls_valid_q, ls_valid_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  logic grant_ls;
  logic grant_if;

  // Round-robin on contention: LS wins unless it won the previous slot.
  assign grant_ls = ls_req && (!if_req || !last_ls_q);
  assign grant_if = if_req && !grant_ls;

  // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_ls_d   = last_ls_q;
    owner_ls_d  = owner_ls_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    busy_d      = 1'b0;
    if_gnt_d    = 1'b0;
    ls_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    ls_valid_d  = 1'b0;

    case (state_q)
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Last access cycle: capture read data and raise valid next cycle.
          state_d = RESP;
          if (owner_ls_q) begin
            ls_valid_d = 1'b1;
            if (!mem_we_q) begin
              ls_rdata_d = mem_rdata;
            end
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          // Hold the access (including the write strobe) for every cycle.
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
          busy_d   = 1'b1;
        end
      end

      default: begin
        // IDLE and RESP both arbitrate, so back-to-back requests overlap RESP.
        if (grant_ls || grant_if) begin
          state_d    = ACCESS;
          cnt_d      = '0;
          owner_ls_d = grant_ls;
          last_ls_d  = grant_ls;
          mem_addr_d = grant_ls ? ls_addr : if_addr;
          if (grant_ls) begin
            mem_wdata_d = ls_wdata;
          end
          mem_en_d = 1'b1;
          mem_we_d = grant_ls & ls_we;
          busy_d   = 1'b1;
          if_gnt_d = grant_if;
          ls_gnt_d = grant_ls;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_ls_q   <= 1'b0;
      owner_ls_q  <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      ls_gnt_q    <= 1'b0;
      ls_valid_q  <= 1'b0;
      ls_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_ls_q   <= last_ls_d;
      owner_ls_q  <= owner_ls_d;
      if_gnt_q    <= if_gnt_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      ls_gnt_q    <= ls_gnt_d;
      ls_valid_q  <= ls_valid_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_gnt    = ls_gnt_q;
  assign ls_valid  = ls_valid_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: instance A (LATENCY=1) runs reset, a table of single
// transactions and a contention sequence; instance B (LATENCY=3) runs the
// long-access and reset-during-access sequences. Expected read data is queued
// when a request is driven and popped when the owner's valid pulse appears.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] sb_q[$];

  typedef struct {
    logic          is_ls;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  // instance A signals
  logic          a_rst, a_if_req, a_ls_req, a_ls_we;
  logic [AW-1:0] a_if_addr, a_ls_addr, a_mem_addr;
  logic [DW-1:0] a_ls_wdata, a_if_rdata, a_ls_rdata, a_mem_wdata, a_mem_rdata;
  logic          a_if_gnt, a_if_valid, a_ls_gnt, a_ls_valid, a_mem_en, a_mem_we, a_busy;
  // instance B signals
  logic          b_rst, b_if_req, b_ls_req, b_ls_we;
  logic [AW-1:0] b_if_addr, b_ls_addr, b_mem_addr;
  logic [DW-1:0] b_ls_wdata, b_if_rdata, b_ls_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_if_gnt, b_if_valid, b_ls_gnt, b_ls_valid, b_mem_en, b_mem_we, b_busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) dut_a (
    .clk(clk), .rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_valid(a_if_valid),
    .if_rdata(a_if_rdata),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata),
    .ls_gnt(a_ls_gnt), .ls_valid(a_ls_valid), .ls_rdata(a_ls_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_valid(b_if_valid),
    .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_gnt(b_ls_gnt), .ls_valid(b_ls_valid), .ls_rdata(b_ls_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: combinational read, write at the clock edge.
  logic          init_mem;
  logic [DW-1:0] a_mem [0:255];
  logic [DW-1:0] b_mem [0:255];
  assign a_mem_rdata = a_mem[a_mem_addr];
  assign b_mem_rdata = b_mem[b_mem_addr];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
      a_mem[8'h10] <= 16'hBEEF;
      a_mem[8'hFF] <= 16'h7E57;
      b_mem[8'h10] <= 16'hC0DE;
    end else begin
      if (a_mem_en && a_mem_we) a_mem[a_mem_addr] <= a_mem_wdata;
      if (b_mem_en && b_mem_we) b_mem[b_mem_addr] <= b_mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name, input logic [DW-1:0] act);
    logic [DW-1:0] e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got %0h", name, act);
    end else begin
      e = sb_q.pop_front();
      chk(name, 64'(act), 64'(e));
    end
  endtask

  // One complete transaction on instance A with no competing request.
  task automatic run_vec(input int idx, input vec_t v);
    if (v.is_ls) begin
      a_ls_req   = 1'b1;
      a_ls_we    = v.we;
      a_ls_addr  = v.addr;
      a_ls_wdata = v.wdata;
    end else begin
      a_if_req  = 1'b1;
      a_if_addr = v.addr;
    end
    sb_q.push_back(v.exp_rdata);
    tick();
    chk("vec_gnt", 64'({a_ls_gnt, a_if_gnt}), 64'(v.is_ls ? 2'b10 : 2'b01));
    chk("vec_mem_en", 64'(a_mem_en), 64'(1'b1));
    chk("vec_mem_addr", 64'(a_mem_addr), 64'(v.addr));
    chk("vec_mem_we", 64'(a_mem_we), 64'(v.is_ls & v.we));
    if (v.is_ls && v.we) chk("vec_mem_wdata", 64'(a_mem_wdata), 64'(v.wdata));
    a_if_req = 1'b0;
    a_ls_req = 1'b0;
    tick();
    chk("vec_valid", 64'({a_ls_valid, a_if_valid}), 64'(v.is_ls ? 2'b10 : 2'b01));
    chk("vec_resp_mem_en", 64'(a_mem_en), 64'(1'b0));
    sb_check("vec_rdata", v.is_ls ? a_ls_rdata : a_if_rdata);
    $display("vec %0d: %s %s addr=%0h wdata=%0h if_rdata=%0h ls_rdata=%0h", idx,
             v.is_ls ? "LS" : "IF", v.we ? "WR" : "RD", v.addr, v.wdata, a_if_rdata, a_ls_rdata);
    tick();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 16'h1234, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'h1234};
    vecs[3] = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 1'b1, 8'h30, 16'hA5A5, 16'h1234};
    vecs[5] = '{1'b0, 1'b0, 8'h30, 16'h0000, 16'hA5A5};
    vecs[6] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
    vecs[7] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'h7E57};
    vecs[8] = '{1'b1, 1'b1, 8'h00, 16'hFFFF, 16'hBEEF};
    vecs[9] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'hFFFF};

    init_mem  = 1'b1;
    a_rst = 1'b1; a_if_req = 1'b1; a_if_addr = 8'h10;
    a_ls_req = 1'b0; a_ls_we = 1'b0; a_ls_addr = '0; a_ls_wdata = '0;
    b_rst = 1'b1; b_if_req = 1'b0; b_if_addr = '0;
    b_ls_req = 1'b0; b_ls_we = 1'b0; b_ls_addr = '0; b_ls_wdata = '0;

    // Reset held two cycles with a pending fetch: every output stays 0.
    tick();
    tick();
    chk("reset_outputs_a", 64'({a_if_gnt, a_if_valid, a_if_rdata, a_ls_gnt, a_ls_valid, a_ls_rdata,
                                a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_busy}), 64'(0));
    chk("reset_outputs_b", 64'({b_if_gnt, b_if_valid, b_if_rdata, b_ls_gnt, b_ls_valid, b_ls_rdata,
                                b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_busy}), 64'(0));
    a_rst = 1'b0;
    b_rst = 1'b0;
    init_mem = 1'b0;
    sb_q.push_back(16'hBEEF);
    tick();
    chk("post_reset_if_gnt", 64'(a_if_gnt), 64'(1'b1));
    chk("post_reset_mem_addr", 64'(a_mem_addr), 64'(8'h10));
    chk("post_reset_busy", 64'(a_busy), 64'(1'b1));
    a_if_req = 1'b0;
    tick();
    chk("post_reset_if_valid", 64'(a_if_valid), 64'(1'b1));
    sb_check("post_reset_if_rdata", a_if_rdata);
    $display("reset: fetch after release if_rdata=%0h", a_if_rdata);
    tick();

    // Table of single transactions.
    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Contention: both requesters held high from reset release.
    a_rst = 1'b1; a_if_req = 1'b1; a_ls_req = 1'b1;
    a_ls_we = 1'b0; a_ls_addr = 8'h10; a_if_addr = 8'h20;
    tick();
    tick();
    a_rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      logic exp_ls;
      exp_ls = (g % 2 == 0);
      sb_q.push_back(exp_ls ? 16'hBEEF : 16'h1234);
      tick();
      chk("contend_gnt", 64'({a_ls_gnt, a_if_gnt}), 64'(exp_ls ? 2'b10 : 2'b01));
      tick();
      chk("contend_valid", 64'({a_ls_valid, a_if_valid}), 64'(exp_ls ? 2'b10 : 2'b01));
      sb_check("contend_rdata", exp_ls ? a_ls_rdata : a_if_rdata);
      $display("contend grant %0d: owner=%s", g, exp_ls ? "LS" : "IF");
    end
    a_if_req = 1'b0;
    a_ls_req = 1'b0;
    tick();
    chk("contend_idle_mem_en", 64'(a_mem_en), 64'(1'b0));

    // LATENCY=3 fetch, with a request raised mid-access that must wait for RESP.
    b_if_req = 1'b1; b_if_addr = 8'h10;
    sb_q.push_back(16'hC0DE);
    tick();
    chk("l3_c1_gnt_en", 64'({b_if_gnt, b_mem_en, b_busy}), 64'(3'b111));
    b_if_req = 1'b0;
    tick();
    chk("l3_c2_gnt_en", 64'({b_if_gnt, b_mem_en, b_if_valid}), 64'(3'b010));
    b_if_req = 1'b1;
    tick();
    chk("l3_c3_gnt_en", 64'({b_if_gnt, b_mem_en, b_if_valid}), 64'(3'b010));
    tick();
    chk("l3_c4_valid", 64'({b_if_gnt, b_mem_en, b_if_valid}), 64'(3'b001));
    sb_check("l3_c4_rdata", b_if_rdata);
    tick();
    chk("l3_regrant", 64'(b_if_gnt), 64'(1'b1));
    b_if_req = 1'b0;
    sb_q.push_back(16'hC0DE);
    tick();
    tick();
    chk("l3_regrant_en", 64'({b_mem_en, b_if_valid}), 64'(2'b10));
    tick();
    chk("l3_regrant_valid", 64'({b_mem_en, b_if_valid}), 64'(2'b01));
    sb_check("l3_regrant_rdata", b_if_rdata);
    $display("latency3 fetch: if_rdata=%0h", b_if_rdata);
    tick();

    // Reset during the second access cycle abandons the load.
    b_ls_req = 1'b1; b_ls_we = 1'b0; b_ls_addr = 8'h10;
    tick();
    chk("abort_gnt", 64'(b_ls_gnt), 64'(1'b1));
    b_ls_req = 1'b0;
    tick();
    chk("abort_access2_en", 64'(b_mem_en), 64'(1'b1));
    b_rst = 1'b1;
    tick();
    chk("abort_outputs", 64'({b_mem_en, b_busy, b_ls_valid, b_if_valid, b_if_rdata, b_ls_rdata}), 64'(0));
    b_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_quiet", 64'({b_mem_en, b_mem_we, b_ls_valid, b_if_valid, b_ls_gnt, b_if_gnt}), 64'(0));
    end
    $display("abort: no activity after reset mid-access");

    chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
